led_code_scheduler: RTL and testbench

Sequencer that shares the single front-panel status LED among four status requesters on the ADC board. Each requester flashes a distinct blink code: requester n shows n+1 pulses followed by a gap. Requests are captured on rising edge and held pending until shown. A fixed-priority arbiter picks the next code, and a tick-based state machine drives the LED. The block runs in the 10 MHz housekeeping domain and replaces free-running blink counters on the board status LED.

---
 rtl/led_code_scheduler_if.sv | 36 +++
 rtl/led_code_scheduler.sv | 168 ++++++++++++++++
 tb/tb_led_code_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_code_scheduler_if.sv
// rtl/led_code_scheduler_if.sv - request/status bundle between the LED code scheduler and its users
//
// Signals:
//   req      [3:0] status request levels; a rising edge asks for one blink code
//   led            LED drive
//   busy           a blink code sequence is in progress
//   grant_id [1:0] requester currently (or last) shown
//   done           one-cycle pulse on the last cycle of a sequence
//   pending  [3:0] captured requests not yet shown
// Modports: master = request side (drives req), slave = scheduler side.
interface led_code_scheduler_if;
  logic [3:0] req;
  logic       led;
  logic       busy;
  logic [1:0] grant_id;
  logic       done;
  logic [3:0] pending;

  modport master (
    output req,
    input  led,
    input  busy,
    input  grant_id,
    input  done,
    input  pending
  );

  modport slave (
    input  req,
    output led,
    output busy,
    output grant_id,
    output done,
    output pending
  );
endinterface

// File: rtl/led_code_scheduler.sv
// rtl/led_code_scheduler.sv - shares one status LED among four requesters as n+1 pulse blink codes
//
// Ports:
//   gclk10m_buf  in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   bus          slave modport of led_code_scheduler_if (req in; led, busy, grant_id, done, pending out)
// Parameters: TICK_DIV clocks per tick, ON_TICKS / OFF_TICKS / GAP_TICKS phase lengths in ticks,
//   HB_TICKS heartbeat half-period in ticks.
// Optional feature macro: LED_HEARTBEAT_EN (led shows a heartbeat while idle).
module led_code_scheduler #(
  parameter int TICK_DIV  = 500000,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4,
  parameter int GAP_TICKS = 20,
  parameter int HB_TICKS  = 10
) (
  input  logic                 gclk10m_buf,
  input  logic                 rst,
  led_code_scheduler_if.slave  bus
);

  if (TICK_DIV < 1 || TICK_DIV > 16777216 || ON_TICKS < 1 || ON_TICKS > 255 ||
      OFF_TICKS < 1 || OFF_TICKS > 255 || GAP_TICKS < 1 || GAP_TICKS > 255 ||
      HB_TICKS < 1 || HB_TICKS > 255) begin : g_bad_param
    $error("led_code_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  localparam logic [23:0] LP_TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [7:0]  LP_ON_LAST   = 8'(ON_TICKS - 1);
  localparam logic [7:0]  LP_OFF_LAST  = 8'(OFF_TICKS - 1);
  localparam logic [7:0]  LP_GAP_LAST  = 8'(GAP_TICKS - 1);

  state_t      r_state;
  logic [3:0]  r_req_q;
  logic [3:0]  r_pending;
  logic [23:0] r_tick_cnt;
  logic [7:0]  r_phase;
  logic [1:0]  r_pulse;
  logic [1:0]  r_grant;
  logic        r_led;

  state_t      w_state_nxt;
  logic        w_led_nxt;
  logic [1:0]  w_grant_nxt;
  logic [1:0]  w_pulse_nxt;
  logic        w_start;
  logic        w_done;
  logic        w_tick;
  logic [1:0]  w_first;
  logic [3:0]  w_set;
  logic [3:0]  w_clr;
  logic        w_hb_nxt;

  assign w_tick = (r_tick_cnt == LP_TICK_LAST);
  assign w_set  = bus.req & ~r_req_q;
  assign w_clr  = w_done ? (4'b0001 << r_grant) : 4'b0000;

  // Fixed priority: lowest set pending bit wins.
  always_comb begin
    w_first = 2'd0;
    if (r_pending[0])      w_first = 2'd0;
    else if (r_pending[1]) w_first = 2'd1;
    else if (r_pending[2]) w_first = 2'd2;
    else if (r_pending[3]) w_first = 2'd3;
  end

`ifdef LED_HEARTBEAT_EN
  localparam logic [7:0] LP_HB_LAST = 8'(HB_TICKS - 1);
  logic [7:0] r_hb_cnt;
  logic       r_hb;
  logic       w_hb_step;

  // The heartbeat only advances while idle, so it resumes where it stopped.
  assign w_hb_step = (r_state == S_IDLE) && w_tick;
  assign w_hb_nxt  = (w_hb_step && (r_hb_cnt == LP_HB_LAST)) ? ~r_hb : r_hb;

  always_ff @(posedge gclk10m_buf) begin
    if (rst) begin
      r_hb_cnt <= 8'd0;
      r_hb     <= 1'b0;
    end else if (w_hb_step) begin
      r_hb_cnt <= (r_hb_cnt == LP_HB_LAST) ? 8'd0 : r_hb_cnt + 8'd1;
      r_hb     <= w_hb_nxt;
    end
  end
`else
  assign w_hb_nxt = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_grant_nxt = r_grant;
    w_pulse_nxt = r_pulse;
    w_start     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_led_nxt = w_hb_nxt;
        if (|r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = S_ON;
          w_led_nxt   = 1'b1;
          w_pulse_nxt = 2'd0;
          w_grant_nxt = w_first;
        end
      end
      S_ON: begin
        if (w_tick && (r_phase == LP_ON_LAST)) begin
          w_led_nxt   = 1'b0;
          w_pulse_nxt = r_pulse + 2'd1;
          // r_pulse still holds the pulses completed before this one, so
          // equality with grant_id means grant_id+1 pulses are now done.
          w_state_nxt = (r_pulse == r_grant) ? S_GAP : S_OFF;
        end
      end
      S_OFF: begin
        if (w_tick && (r_phase == LP_OFF_LAST)) begin
          w_led_nxt   = 1'b1;
          w_state_nxt = S_ON;
        end
      end
      S_GAP: begin
        if (w_tick && (r_phase == LP_GAP_LAST)) begin
          w_done      = 1'b1;
          w_led_nxt   = w_hb_nxt;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk10m_buf) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_q    <= 4'd0;
      r_pending  <= 4'd0;
      r_tick_cnt <= 24'd0;
      r_phase    <= 8'd0;
      r_pulse    <= 2'd0;
      r_grant    <= 2'd0;
      r_led      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_q   <= bus.req;
      // A new edge on the same cycle as its clear keeps the bit set.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_pulse   <= w_pulse_nxt;
      r_grant   <= w_grant_nxt;
      r_led     <= w_led_nxt;
      // Restarting the divider aligns every tick with the LED rising edge.
      if (w_start || w_tick) r_tick_cnt <= 24'd0;
      else                   r_tick_cnt <= r_tick_cnt + 24'd1;
      if (w_state_nxt != r_state)             r_phase <= 8'd0;
      else if (w_tick && r_state != S_IDLE)   r_phase <= r_phase + 8'd1;
    end
  end

  assign bus.led      = r_led;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant;
  assign bus.done     = w_done;
  assign bus.pending  = r_pending;

endmodule

// File: tb/tb_led_code_scheduler.sv
// tb/tb_led_code_scheduler.sv - randomized and directed self-checking bench for led_code_scheduler
module tb_led_code_scheduler;
  localparam int D   = 4;
  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int GAP = 3;
  localparam int HB  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_code_scheduler_if bus ();

  led_code_scheduler #(
    .TICK_DIV(D), .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP), .HB_TICKS(HB)
  ) dut (
    .gclk10m_buf(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a timeline of cycles since the led rising edge.
  logic [3:0] m_pend = 4'd0;
  logic [3:0] m_reqq = 4'd0;
  bit         m_active = 1'b0;
  int         m_id = 0;
  int         m_t = 0;
  int         m_tc = 0;
  bit         m_hb = 1'b0;
  int         m_hbc = 0;

  function automatic int seq_len(input int id);
    return D * ((id + 1) * ON + id * OFF + GAP);
  endfunction

  function automatic bit led_at(input int id, input int t);
    int k;
    k = t / D;
    if (k >= (id + 1) * ON + id * OFF) return 1'b0;
    return (k % (ON + OFF)) < ON;
  endfunction

  function automatic bit m_done();
    return m_active && (m_t == seq_len(m_id) - 1);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq);
    bit tick;
    bit start;
    logic [3:0] clr;
    if (r) begin
      m_pend = 4'd0; m_reqq = 4'd0; m_active = 1'b0; m_id = 0; m_t = 0;
      m_tc = 0; m_hb = 1'b0; m_hbc = 0;
    end else begin
      tick  = (m_tc == D - 1);
      start = 1'b0;
      clr   = 4'd0;
      if (!m_active && tick) begin
        m_hbc++;
        if (m_hbc == HB) begin m_hbc = 0; m_hb = ~m_hb; end
      end
      if (m_active) begin
        if (m_done()) begin m_active = 1'b0; clr[m_id] = 1'b1; end
        else m_t++;
      end else if (m_pend != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_id = i;
        m_active = 1'b1;
        m_t = 0;
        start = 1'b1;
      end
      m_tc   = (start || tick) ? 0 : m_tc + 1;
      m_pend = (m_pend & ~clr) | (rq & ~m_reqq);
      m_reqq = rq;
    end
  endtask

  function automatic bit m_led();
    if (m_active) return led_at(m_id, m_t);
`ifdef LED_HEARTBEAT_EN
    return m_hb;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, bus.req);
      #1;
      check("led", int'(bus.led), int'(m_led()));
      check("busy", int'(bus.busy), int'(m_active));
      check("grant_id", int'(bus.grant_id), m_id);
      check("done", int'(bus.done), int'(m_done()));
      check("pending", int'(bus.pending), int'(m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!bus.busy && n < 50) begin step(); n++; end
    if (!bus.busy) check(name, 0, 1);
  endtask

  task automatic run_code(input logic [3:0] r, output int len, output int rises);
    bit prev;
    @(negedge clk) bus.req = r;
    @(negedge clk) bus.req = 4'd0;
    wait_busy("start_timeout");
    len = 0; rises = 0; prev = 1'b0;
    while (bus.busy && len < 500) begin
      len++;
      if (bus.led && !prev) rises++;
      prev = bus.led;
      step();
    end
  endtask

  int n, m, len, rises, inj;
  bit prev;

  initial begin
    bus.req = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_grant", int'(bus.grant_id), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single request on req[0]
    bus.req = 4'b0001;
    step();
    check("single_pend_set", int'(bus.pending), 1);
    check("single_not_busy_yet", int'(bus.busy), 0);
    @(negedge clk) bus.req = 4'd0;
    step();
    check("single_led_rise", int'(bus.led), 1);
    check("single_busy", int'(bus.busy), 1);
    n = 0;
    while (bus.led && n < 100) begin n++; step(); end
    check("single_on_cycles", n, 8);
    m = 1;
    while (!bus.done && m < 100) begin step(); m++; end
    check("single_gap_cycles", m, 12);
    check("single_grant", int'(bus.grant_id), 0);
    step();
    check("single_idle", int'(bus.busy), 0);
    check("single_pend_clr", int'(bus.pending), 0);

    // Three-pulse code
    repeat (3) step();
    run_code(4'b0100, len, rises);
    check("code2_len", len, 44);
    check("code2_pulses", rises, 3);

    // Priority without preemption
    repeat (3) step();
    @(negedge clk) bus.req = 4'b1000;
    @(negedge clk) bus.req = 4'd0;
    wait_busy("code3_start");
    len = 0; rises = 0; prev = 1'b0; inj = 0;
    while (bus.busy && len < 500) begin
      len++;
      if (bus.led && !prev) rises++;
      prev = bus.led;
      if (inj == 1) begin bus.req = 4'd0; inj = 2; end
      if (rises == 2 && inj == 0) begin bus.req = 4'b0011; inj = 1; end
      step();
    end
    check("code3_len", len, 56);
    check("code3_pulses", rises, 4);
    check("code3_pend_during", int'(bus.pending), 3);
    step();
    check("prio_first_busy", int'(bus.busy), 1);
    check("prio_first_grant", int'(bus.grant_id), 0);
    n = 0;
    while (bus.busy && n < 500) begin step(); n++; end
    step();
    check("prio_second_busy", int'(bus.busy), 1);
    check("prio_second_grant", int'(bus.grant_id), 1);

    // Re-request on own done cycle
    n = 0;
    while (!bus.done && n < 500) begin step(); n++; end
    check("rereq_done_seen", int'(bus.done), 1);
    bus.req = 4'b0010;
    step();
    check("rereq_pend_kept", int'(bus.pending), 2);
    @(negedge clk) bus.req = 4'd0;
    step();
    check("rereq_repeat_busy", int'(bus.busy), 1);
    check("rereq_repeat_grant", int'(bus.grant_id), 1);

    // Reset during ON phase with another request pending
    @(negedge clk) bus.req = 4'b0100;
    @(negedge clk) rst = 1'b1;
    step();
    check("midrst_led", int'(bus.led), 0);
    check("midrst_pending", int'(bus.pending), 0);
    check("midrst_busy", int'(bus.busy), 0);
    @(negedge clk) begin rst = 1'b0; bus.req = 4'd0; end

    // Randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 39) == 0) bus.req[i] = ~bus.req[i];
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk) begin rst = 1'b0; bus.req = 4'd0; end
    repeat (300) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
